mem_width_adapter: RTL and testbench

Converts byte/halfword/word requests from the cart/USB mux into 16-bit beats for the external 16-bit memory controller. Sits directly downstream of the mux on the memory side: it owns the `mem_*` handshake (ready, read data, read valid) and drives a halfword-addressed command port toward the PHY. A 32-bit access is split into two little-endian halfword beats. Sub-halfword writes use byte enables.

---
 rtl/mem_width_adapter_if.sv | 37 +++
 rtl/mem_width_adapter.sv | 165 ++++++++++++++++
 tb/tb_mem_width_adapter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_width_adapter_if.sv
// Bundles the upstream memory request/response signals and the 16-bit PHY
// beat port. The adapter uses the slave view; the environment uses master.
interface mem_width_adapter_if #(
  parameter int HADDR_W = 25
);
  logic               mem_rd;
  logic               mem_wr;
  logic [HADDR_W:0]   mem_addr;
  logic [1:0]         mem_data_width;
  logic [31:0]        mem_wr_data;
  logic               mem_rd_ready;
  logic               mem_wr_ready;
  logic [31:0]        mem_rd_data;
  logic               mem_rd_valid;
  logic               phy_cmd_valid;
  logic               phy_cmd_ready;
  logic               phy_we;
  logic [HADDR_W-1:0] phy_addr;
  logic [1:0]         phy_be;
  logic [15:0]        phy_wdata;
  logic               phy_rd_valid;
  logic [15:0]        phy_rd_data;

  modport slave (
    input  mem_rd, mem_wr, mem_addr, mem_data_width, mem_wr_data,
    output mem_rd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid,
    output phy_cmd_valid, phy_we, phy_addr, phy_be, phy_wdata,
    input  phy_cmd_ready, phy_rd_valid, phy_rd_data
  );

  modport master (
    output mem_rd, mem_wr, mem_addr, mem_data_width, mem_wr_data,
    input  mem_rd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid,
    input  phy_cmd_valid, phy_we, phy_addr, phy_be, phy_wdata,
    output phy_cmd_ready, phy_rd_valid, phy_rd_data
  );
endinterface

// File: rtl/mem_width_adapter.sv
// Splits byte/halfword/word memory requests into 16-bit PHY beats (one
// outstanding), little-endian for words, byte enables for sub-halfword writes.
//
// state    | meaning
// IDLE     | ready for a request; captures write (priority) or read
// ISSUE_LO | first beat command presented until accepted
// WAIT_LO  | read: waiting for first beat data
// ISSUE_HI | word access: second beat command presented until accepted
// WAIT_HI  | word read: waiting for second beat data
module mem_width_adapter #(
  parameter int HADDR_W = 25
) (
  input logic                clk,
  input logic                rst,
  mem_width_adapter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI} state_t;

  state_t             state, state_nxt;
  logic               is_wr_q, is_wr_nxt;
  logic [1:0]         width_q, width_nxt;
  logic [HADDR_W:0]   addr_q, addr_nxt;
  logic [31:0]        wd_q, wd_nxt;
  logic [15:0]        lo_q, lo_nxt;
  logic               cmd_valid_q, cmd_valid_nxt;
  logic               we_q, we_nxt;
  logic [HADDR_W-1:0] paddr_q, paddr_nxt;
  logic [1:0]         be_q, be_nxt;
  logic [15:0]        wdata_q, wdata_nxt;
  logic [31:0]        rd_data_q, rd_data_nxt;
  logic               rd_valid_q, rd_valid_nxt;

  logic               is_word, is_byte;
  logic [HADDR_W-1:0] hi_addr;
  logic [7:0]         lane;

  assign is_word = width_q[1];
  assign is_byte = (width_q == 2'b00);
  // Wraps modulo 2^HADDR_W at the top of memory.
  assign hi_addr = addr_q[HADDR_W:1] + HADDR_W'(1);
  assign lane    = addr_q[0] ? bus.phy_rd_data[15:8] : bus.phy_rd_data[7:0];

  always_comb begin
    state_nxt     = state;
    is_wr_nxt     = is_wr_q;
    width_nxt     = width_q;
    addr_nxt      = addr_q;
    wd_nxt        = wd_q;
    lo_nxt        = lo_q;
    cmd_valid_nxt = cmd_valid_q;
    we_nxt        = we_q;
    paddr_nxt     = paddr_q;
    be_nxt        = be_q;
    wdata_nxt     = wdata_q;
    rd_data_nxt   = rd_data_q;
    rd_valid_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_wr || bus.mem_rd) begin
          is_wr_nxt     = bus.mem_wr;
          width_nxt     = bus.mem_data_width;
          addr_nxt      = bus.mem_addr;
          wd_nxt        = bus.mem_wr_data;
          cmd_valid_nxt = 1'b1;
          we_nxt        = bus.mem_wr;
          paddr_nxt     = bus.mem_addr[HADDR_W:1];
          if (bus.mem_data_width == 2'b00) begin
            be_nxt    = bus.mem_addr[0] ? 2'b10 : 2'b01;
            wdata_nxt = {bus.mem_wr_data[7:0], bus.mem_wr_data[7:0]};
          end else begin
            be_nxt    = 2'b11;
            wdata_nxt = bus.mem_wr_data[15:0];
          end
          state_nxt = ISSUE_LO;
        end
      end
      ISSUE_LO: begin
        if (bus.phy_cmd_ready) begin
          if (is_wr_q && is_word) begin
            paddr_nxt = hi_addr;
            be_nxt    = 2'b11;
            wdata_nxt = wd_q[31:16];
            state_nxt = ISSUE_HI;
          end else begin
            cmd_valid_nxt = 1'b0;
            state_nxt     = is_wr_q ? IDLE : WAIT_LO;
          end
        end
      end
      WAIT_LO: begin
        if (bus.phy_rd_valid) begin
          lo_nxt = bus.phy_rd_data;
          if (is_word) begin
            cmd_valid_nxt = 1'b1;
            paddr_nxt     = hi_addr;
            be_nxt        = 2'b11;
            state_nxt     = ISSUE_HI;
          end else begin
            rd_valid_nxt = 1'b1;
            rd_data_nxt  = is_byte ? {24'h0, lane} : {16'h0, bus.phy_rd_data};
            state_nxt    = IDLE;
          end
        end
      end
      ISSUE_HI: begin
        if (bus.phy_cmd_ready) begin
          cmd_valid_nxt = 1'b0;
          state_nxt     = is_wr_q ? IDLE : WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.phy_rd_valid) begin
          rd_valid_nxt = 1'b1;
          rd_data_nxt  = {bus.phy_rd_data, lo_q};
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      is_wr_q     <= 1'b0;
      width_q     <= 2'b00;
      addr_q      <= '0;
      wd_q        <= '0;
      lo_q        <= '0;
      cmd_valid_q <= 1'b0;
      we_q        <= 1'b0;
      paddr_q     <= '0;
      be_q        <= 2'b00;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      is_wr_q     <= is_wr_nxt;
      width_q     <= width_nxt;
      addr_q      <= addr_nxt;
      wd_q        <= wd_nxt;
      lo_q        <= lo_nxt;
      cmd_valid_q <= cmd_valid_nxt;
      we_q        <= we_nxt;
      paddr_q     <= paddr_nxt;
      be_q        <= be_nxt;
      wdata_q     <= wdata_nxt;
      rd_data_q   <= rd_data_nxt;
      rd_valid_q  <= rd_valid_nxt;
    end
  end

  assign bus.mem_rd_ready  = (state == IDLE);
  assign bus.mem_wr_ready  = (state == IDLE);
  assign bus.mem_rd_data   = rd_data_q;
  assign bus.mem_rd_valid  = rd_valid_q;
  assign bus.phy_cmd_valid = cmd_valid_q;
  assign bus.phy_we        = we_q;
  assign bus.phy_addr      = paddr_q;
  assign bus.phy_be        = be_q;
  assign bus.phy_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_width_adapter.sv
// Directed bench for mem_width_adapter: table of single transactions against
// an always-ready PHY model, plus stall, collision and reset-mid-read sequences.
module tb_mem_width_adapter;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mem_width_adapter_if #(.HADDR_W(25)) bus ();

  mem_width_adapter #(.HADDR_W(25)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [1:0]  w;
    logic [25:0] addr;
    logic [31:0] wd;
    int          k;
    logic [15:0] lo;
    logic [15:0] hi;
    int          nb;
    logic [24:0] a0;
    logic [24:0] a1;
    logic [1:0]  be0;
    logic [1:0]  be1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [24:0] ba[2];
    logic [1:0]  bbe[2];
    logic [15:0] bd[2];
    logic        bwe[2];
    int          nb = 0;
    int          nrdv = 0;
    int          nret = 0;
    int          cnt = 0;
    int          lat = 0;
    int          extra = 0;
    logic        pend = 1'b0;
    bit          done = 1'b0;
    string       tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    check({tag, "_ready_before"}, 64'({bus.mem_rd_ready, bus.mem_wr_ready}), 64'(2'b11));
    bus.mem_wr         = v.we;
    bus.mem_rd         = !v.we;
    bus.mem_data_width = v.w;
    bus.mem_addr       = v.addr;
    bus.mem_wr_data    = v.wd;
    bus.phy_cmd_ready  = 1'b1;
    for (int i = 1; i <= 60 && !done; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.mem_wr = 1'b0;
        bus.mem_rd = 1'b0;
      end
      bus.phy_rd_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus.phy_rd_valid = 1'b1;
          bus.phy_rd_data  = (nret == 0) ? v.lo : v.hi;
          nret++;
          pend = 1'b0;
        end
      end
      if (bus.phy_cmd_valid && bus.phy_cmd_ready) begin
        if (nb < 2) begin
          ba[nb]  = bus.phy_addr;
          bbe[nb] = bus.phy_be;
          bd[nb]  = bus.phy_wdata;
          bwe[nb] = bus.phy_we;
        end
        nb++;
        if (!bus.phy_we) begin
          pend = 1'b1;
          cnt  = v.k;
        end
      end
      if (bus.mem_rd_valid) nrdv++;
      if (bus.mem_rd_ready) begin
        done = 1'b1;
        lat  = i;
      end
    end
    if (!done) check({tag, "_timeout"}, 64'(0), 64'(1));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.phy_rd_valid = 1'b0;
      if (bus.mem_rd_valid) nrdv++;
      if (bus.phy_cmd_valid) extra++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(v.lat));
    check({tag, "_beats"}, 64'(nb), 64'(v.nb));
    check({tag, "_extra_cmd"}, 64'(extra), 64'(0));
    for (int b = 0; b < 2; b++) begin
      if (b < nb && b < v.nb) begin
        check($sformatf("%s_b%0d_addr", tag, b), 64'(ba[b]), 64'((b == 0) ? v.a0 : v.a1));
        check($sformatf("%s_b%0d_be", tag, b), 64'(bbe[b]), 64'((b == 0) ? v.be0 : v.be1));
        check($sformatf("%s_b%0d_we", tag, b), 64'(bwe[b]), 64'(v.we));
        if (v.we) check($sformatf("%s_b%0d_wdata", tag, b), 64'(bd[b]), 64'((b == 0) ? v.d0 : v.d1));
      end
    end
    check({tag, "_rd_valid_pulses"}, 64'(nrdv), 64'(v.we ? 0 : 1));
    check({tag, "_rd_data"}, 64'(bus.mem_rd_data), 64'(v.rdata));
  endtask

  initial begin
    int cnt_cmd;
    int cnt_rdv;
    tests = 0;
    fails = 0;
    //          we    w      addr          wd             k  lo        hi        nb a0           a1      be0    be1    d0        d1        rdata          lat
    vecs[0] = '{1'b1, 2'b11, 26'h0000000, 32'h0123ABCD, 1, 16'h0000, 16'h0000, 2, 25'h0000000, 25'h01, 2'b11, 2'b11, 16'hABCD, 16'h0123, 32'h00000000, 3};
    vecs[1] = '{1'b0, 2'b11, 26'h0000000, 32'h00000000, 2, 16'hABCD, 16'h0123, 2, 25'h0000000, 25'h01, 2'b11, 2'b11, 16'h0000, 16'h0000, 32'h0123ABCD, 7};
    vecs[2] = '{1'b1, 2'b00, 26'h0000013, 32'h0000005A, 1, 16'h0000, 16'h0000, 1, 25'h0000009, 25'h00, 2'b10, 2'b00, 16'h5A5A, 16'h0000, 32'h0123ABCD, 2};
    vecs[3] = '{1'b0, 2'b00, 26'h0000013, 32'h00000000, 1, 16'h77AB, 16'h0000, 1, 25'h0000009, 25'h00, 2'b10, 2'b00, 16'h0000, 16'h0000, 32'h00000077, 3};
    vecs[4] = '{1'b0, 2'b00, 26'h0000012, 32'h00000000, 1, 16'h77AB, 16'h0000, 1, 25'h0000009, 25'h00, 2'b01, 2'b00, 16'h0000, 16'h0000, 32'h000000AB, 3};
    vecs[5] = '{1'b1, 2'b01, 26'h0000020, 32'hFFFFBEEF, 1, 16'h0000, 16'h0000, 1, 25'h0000010, 25'h00, 2'b11, 2'b00, 16'hBEEF, 16'h0000, 32'h000000AB, 2};
    vecs[6] = '{1'b0, 2'b01, 26'h0000020, 32'h00000000, 3, 16'hBEEF, 16'h0000, 1, 25'h0000010, 25'h00, 2'b11, 2'b00, 16'h0000, 16'h0000, 32'h0000BEEF, 5};
    vecs[7] = '{1'b0, 2'b10, 26'h3FFFFFE, 32'h00000000, 1, 16'h1111, 16'h2222, 2, 25'h1FFFFFF, 25'h00, 2'b11, 2'b11, 16'h0000, 16'h0000, 32'h22221111, 5};
    vecs[8] = '{1'b1, 2'b11, 26'h0000005, 32'hCAFEF00D, 1, 16'h0000, 16'h0000, 2, 25'h0000002, 25'h03, 2'b11, 2'b11, 16'hF00D, 16'hCAFE, 32'h22221111, 3};
    vecs[9] = '{1'b1, 2'b00, 26'h0000004, 32'h123456C3, 1, 16'h0000, 16'h0000, 1, 25'h0000002, 25'h00, 2'b01, 2'b00, 16'hC3C3, 16'h0000, 32'h22221111, 2};

    rst                = 1'b1;
    bus.mem_rd         = 1'b0;
    bus.mem_wr         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_data_width = 2'b00;
    bus.mem_wr_data    = '0;
    bus.phy_cmd_ready  = 1'b0;
    bus.phy_rd_valid   = 1'b0;
    bus.phy_rd_data    = '0;
    repeat (3) @(negedge clk);
    check("reset_readies", 64'({bus.mem_rd_ready, bus.mem_wr_ready}), 64'(2'b11));
    check("reset_phy", 64'({bus.phy_cmd_valid, bus.phy_we, bus.phy_addr, bus.phy_be, bus.phy_wdata}), 64'(0));
    check("reset_rd", 64'({bus.mem_rd_valid, bus.mem_rd_data}), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // PHY stalls the low beat of a word write for five cycles.
    @(negedge clk);
    bus.phy_cmd_ready  = 1'b0;
    bus.mem_wr         = 1'b1;
    bus.mem_data_width = 2'b11;
    bus.mem_addr       = 26'h40;
    bus.mem_wr_data    = 32'hDEADBEEF;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) bus.mem_wr = 1'b0;
      if (i == 2) begin
        bus.mem_rd         = 1'b1;
        bus.mem_addr       = 26'h80;
        bus.mem_data_width = 2'b01;
      end
      if (i == 4) bus.mem_rd = 1'b0;
      check($sformatf("stall_lo_c%0d", i),
            64'({bus.mem_wr_ready, bus.phy_cmd_valid, bus.phy_we, bus.phy_addr, bus.phy_be, bus.phy_wdata}),
            64'({1'b0, 1'b1, 1'b1, 25'h20, 2'b11, 16'hBEEF}));
    end
    bus.phy_cmd_ready = 1'b1;
    @(negedge clk);
    check("stall_hi", 64'({bus.phy_cmd_valid, bus.phy_we, bus.phy_addr, bus.phy_be, bus.phy_wdata}),
          64'({1'b1, 1'b1, 25'h21, 2'b11, 16'hDEAD}));
    @(negedge clk);
    check("stall_done", 64'({bus.mem_rd_ready, bus.mem_wr_ready, bus.phy_cmd_valid}), 64'(3'b110));
    cnt_cmd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.phy_cmd_valid) cnt_cmd++;
    end
    check("busy_req_ignored", 64'(cnt_cmd), 64'(0));

    // Simultaneous read and write: only the write is issued.
    bus.mem_rd         = 1'b1;
    bus.mem_wr         = 1'b1;
    bus.mem_data_width = 2'b01;
    bus.mem_addr       = 26'h8;
    bus.mem_wr_data    = 32'h00001234;
    @(negedge clk);
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    check("collide_beat", 64'({bus.phy_cmd_valid, bus.phy_we, bus.phy_addr, bus.phy_be, bus.phy_wdata}),
          64'({1'b1, 1'b1, 25'h4, 2'b11, 16'h1234}));
    cnt_cmd = 0;
    cnt_rdv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.phy_cmd_valid) cnt_cmd++;
      if (bus.mem_rd_valid) cnt_rdv++;
    end
    check("collide_no_read", 64'({cnt_cmd[7:0], cnt_rdv[7:0]}), 64'(0));

    // Reset while waiting for read data; a late beat must be ignored.
    bus.mem_rd         = 1'b1;
    bus.mem_data_width = 2'b01;
    bus.mem_addr       = 26'h10;
    @(negedge clk);
    bus.mem_rd = 1'b0;
    @(negedge clk);
    check("rst_in_wait_lo", 64'({bus.mem_rd_ready, bus.phy_cmd_valid}), 64'(2'b00));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_forces_idle", 64'({bus.mem_rd_ready, bus.mem_wr_ready, bus.phy_cmd_valid}), 64'(3'b110));
    bus.phy_rd_valid = 1'b1;
    bus.phy_rd_data  = 16'h9999;
    cnt_rdv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.phy_rd_valid = 1'b0;
      if (bus.mem_rd_valid) cnt_rdv++;
    end
    check("rst_no_rd_valid", 64'(cnt_rdv), 64'(0));
    check("rst_rd_data", 64'(bus.mem_rd_data), 64'(0));
    check("rst_readies", 64'({bus.mem_rd_ready, bus.mem_wr_ready}), 64'(2'b11));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
